// File: rtl/writeback_arbiter_pkg.sv
// Shared widths, write-port payload type and helpers for the writeback arbiter.
package writeback_arbiter_pkg;

  localparam int unsigned XLEN         = 32;
  localparam int unsigned AW           = 5;
  localparam int unsigned NREGS        = 1 << AW;
  localparam int unsigned LQ_DEPTH_DEF = 4;

  // One register-file write: enable, address, data
  typedef struct packed {
    logic            we;
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
  } wb_req_t;

  // One-hot decode of a register index into a per-register mask
  function automatic logic [NREGS-1:0] rd_onehot(input logic [AW-1:0] rd);
    logic [NREGS-1:0] m;
    m     = '0;
    m[rd] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/wb_load_queue.sv
// In-order FIFO of outstanding load destinations. Caller gates push/pop so
// that push never lands on a full queue unless a pop happens the same edge.
module wb_load_queue #(
  parameter int unsigned AW    = 5,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [AW-1:0]              push_rd,
  output logic [AW-1:0]              head_rd,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic [DEPTH-1:0]           ent_valid,
  output logic [DEPTH*AW-1:0]        ent_rd
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [AW-1:0]    rd_q [DEPTH];

  // Pointer/count/valid next state; pop clears before push sets so a
  // push+pop on a full queue (head==tail) leaves the slot valid.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    vld_d  = vld_q;
    cnt_d  = cnt_q + CW'(push) - CW'(pop);
    if (pop) begin
      vld_d[head_q] = 1'b0;
      head_d        = head_q + PW'(1);
    end
    if (push) begin
      vld_d[tail_q] = 1'b1;
      tail_d        = tail_q + PW'(1);
    end
  end

  // Control state with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      vld_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      vld_q  <= vld_d;
    end
  end

  // Destination storage; qualified by vld_q so no reset needed
  always_ff @(posedge clk) begin
    if (push) begin
      rd_q[tail_q] <= push_rd;
    end
  end

  // Flatten entries for the busy-mask decode
  always_comb begin
    ent_rd = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      ent_rd[i*AW +: AW] = rd_q[i];
    end
  end

  assign head_rd   = rd_q[head_q];
  assign count     = cnt_q;
  assign full      = (cnt_q == CW'(DEPTH));
  assign empty     = (cnt_q == CW'(0));
  assign ent_valid = vld_q;

endmodule

// File: rtl/writeback_arbiter.sv
// Merges ALU results and in-order load responses into one registered
// register-file write per cycle; exports a busy mask for outstanding loads.
// Optional WB_BYPASS_EN adds same-cycle forwarding outputs byp_*.
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int unsigned LQ_DEPTH = LQ_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alu_valid,
  input  logic [AW-1:0]    alu_rd,
  input  logic [XLEN-1:0]  alu_data,
  output logic             alu_ready,
  input  logic             ld_issue,
  input  logic [AW-1:0]    ld_issue_rd,
  input  logic             ld_resp_valid,
  input  logic [XLEN-1:0]  ld_resp_data,
  output logic             lq_full,
  output logic [NREGS-1:0] busy_mask,
  output logic             ld_err,
`ifdef WB_BYPASS_EN
  output logic             byp_valid,
  output logic [AW-1:0]    byp_addr,
  output logic [XLEN-1:0]  byp_data,
`endif
  output logic             reg_we,
  output logic [AW-1:0]    w_addr,
  output logic [XLEN-1:0]  w_data
);

  localparam int unsigned CW = $clog2(LQ_DEPTH + 1);

  logic                   lq_push;
  logic                   lq_pop;
  logic [AW-1:0]          lq_head_rd;
  logic [CW-1:0]          lq_count;
  logic                   lq_empty;
  logic [LQ_DEPTH-1:0]    lq_ent_valid;
  logic [LQ_DEPTH*AW-1:0] lq_ent_rd;
  logic                   resp_err;
  logic                   issue_err;
  logic                   alu_fire;
  logic                   ld_err_q, ld_err_d;
  wb_req_t                wb_q, wb_d;

  wb_load_queue #(
    .AW    (AW),
    .DEPTH (LQ_DEPTH)
  ) u_lq (
    .clk       (clk),
    .rst       (rst),
    .push      (lq_push),
    .pop       (lq_pop),
    .push_rd   (ld_issue_rd),
    .head_rd   (lq_head_rd),
    .count     (lq_count),
    .full      (lq_full),
    .empty     (lq_empty),
    .ent_valid (lq_ent_valid),
    .ent_rd    (lq_ent_rd)
  );

  // Busy mask: any queued load targeting r; x0 is never busy
  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < int'(LQ_DEPTH); i++) begin
      if (lq_ent_valid[i]) begin
        busy_mask = busy_mask | rd_onehot(lq_ent_rd[i*AW +: AW]);
      end
    end
    busy_mask[0] = 1'b0;
  end

  // Queue control and error detection; a same-cycle issue cannot feed a
  // response because the response needs the pre-existing head.
  always_comb begin
    lq_pop    = ld_resp_valid && !lq_empty;
    lq_push   = ld_issue && (!lq_full || lq_pop);
    resp_err  = ld_resp_valid && (lq_count == CW'(0));
    issue_err = ld_issue && lq_full && !lq_pop;
    ld_err_d  = ld_err_q || resp_err || issue_err;
  end

  // Source selection: load response wins; WAW interlock holds the ALU off
  // registers an older load will still overwrite
  always_comb begin
    alu_ready = !ld_resp_valid && !busy_mask[alu_rd];
    alu_fire  = alu_valid && alu_ready;
    wb_d      = '0;
    if (lq_pop) begin
      wb_d.we   = (lq_head_rd != '0);
      wb_d.addr = lq_head_rd;
      wb_d.data = ld_resp_data;
    end else if (alu_fire) begin
      wb_d.we   = (alu_rd != '0);
      wb_d.addr = alu_rd;
      wb_d.data = alu_data;
    end
  end

  // Registered write port and sticky error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_q     <= '0;
      ld_err_q <= 1'b0;
    end else begin
      ld_err_q <= ld_err_d;
      wb_q.we  <= wb_d.we;
      if (wb_d.we) begin
        wb_q.addr <= wb_d.addr;
        wb_q.data <= wb_d.data;
      end
    end
  end

  assign reg_we = wb_q.we;
  assign w_addr = wb_q.addr;
  assign w_data = wb_q.data;
  assign ld_err = ld_err_q;

`ifdef WB_BYPASS_EN
  assign byp_valid = wb_d.we;
  assign byp_addr  = wb_d.addr;
  assign byp_data  = wb_d.data;
`endif

endmodule
